// File: rtl/skeeball_display.sv
// Two-digit multiplexed seven-segment driver for the skeeball cabinet.
// Shows the live score, flashes the final score, and tracks the session high score.
module skeeball_display #(
  parameter int SCAN_DIV    = 1000,
  parameter int FLASH_DIV   = 25000,
  parameter int FLASH_COUNT = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       playstate,
  input  logic [7:0] score,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic [7:0] high_score,
  output logic       new_high
);

  localparam int SCAN_W  = $clog2(SCAN_DIV);
  localparam int FLASH_W = $clog2(FLASH_DIV);
  localparam int PHASE_N = 2 * FLASH_COUNT;
  localparam int PHASE_W = $clog2(PHASE_N);

  typedef enum logic [1:0] {IDLE, PLAY, FLASH} state_t;

  state_t             state_q, state_d;
  logic [SCAN_W-1:0]  scan_cnt;
  logic               sel;          // 0 = ones slot, 1 = tens slot
  logic [FLASH_W-1:0] flash_cnt;
  logic [PHASE_W-1:0] phase_cnt;
  logic [7:0]         final_score;
  logic               game_end;
  logic               flash_done;
  logic               enter_play;
  logic [7:0]         disp;
  logic [3:0]         nib;
  logic [6:0]         seg_d;
  logic [1:0]         an_d;

  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'd0: decode = 7'b1111110;
      4'd1: decode = 7'b0110000;
      4'd2: decode = 7'b1101101;
      4'd3: decode = 7'b1111001;
      4'd4: decode = 7'b0110011;
      4'd5: decode = 7'b1011011;
      4'd6: decode = 7'b1011111;
      4'd7: decode = 7'b1110000;
      4'd8: decode = 7'b1111111;
      4'd9: decode = 7'b1111011;
      default: decode = 7'b0000001;
    endcase
  endfunction

  assign game_end   = (state_q == PLAY) && !playstate;
  assign enter_play = (state_q != PLAY) && playstate;
  assign flash_done = (state_q == FLASH)
                   && (flash_cnt == FLASH_W'(FLASH_DIV - 1))
                   && (phase_cnt == PHASE_W'(PHASE_N - 1));

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (playstate) state_d = PLAY;
      PLAY:    if (!playstate) state_d = FLASH;
      FLASH:   if (playstate) state_d = PLAY;
               else if (flash_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    disp = high_score;
    case (state_q)
      PLAY:    disp = score;
      FLASH:   disp = final_score;
      default: disp = high_score;
    endcase
    nib   = sel ? disp[7:4] : disp[3:0];
    seg_d = decode(nib);
    an_d  = sel ? 2'b10 : 2'b01;
    // Blank a leading zero but keep the anode pulsing for even brightness.
    if (sel && (disp[7:4] == 4'd0)) seg_d = 7'b0000000;
    if ((state_q == FLASH) && phase_cnt[0]) begin
      seg_d = 7'b0000000;
      an_d  = 2'b00;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      scan_cnt    <= '0;
      sel         <= 1'b0;
      flash_cnt   <= '0;
      phase_cnt   <= '0;
      final_score <= 8'h00;
      high_score  <= 8'h00;
      new_high    <= 1'b0;
      seg         <= 7'b0000000;
      an          <= 2'b00;
    end else begin
      state_q <= state_d;
      seg     <= seg_d;
      an      <= an_d;

      if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
        scan_cnt <= '0;
        sel      <= ~sel;
      end else begin
        scan_cnt <= scan_cnt + SCAN_W'(1);
      end

      if (game_end) begin
        flash_cnt <= '0;
        phase_cnt <= '0;
      end else if (state_q == FLASH) begin
        if (flash_cnt == FLASH_W'(FLASH_DIV - 1)) begin
          flash_cnt <= '0;
          phase_cnt <= phase_cnt + PHASE_W'(1);
        end else begin
          flash_cnt <= flash_cnt + FLASH_W'(1);
        end
      end

      if (game_end) begin
        final_score <= score;
        if (score > high_score) begin
          high_score <= score;
          new_high   <= 1'b1;
        end
      end else if (enter_play) begin
        new_high <= 1'b0;
      end
    end
  end

endmodule
